// File: rtl/led_counter_sequencer.sv
// -----------------------------------------------------------------------------
// led_counter_sequencer
//
// Run-control and pacing controller for the Go Board 4-bit LED binary counter.
// Owns the tick divider and the 4-bit count register. Four debounced switch
// levels are edge-detected (rising edges only) and control the counter:
//   Switch_1 : run/pause toggle
//   Switch_2 : direction toggle (up/down), takes effect from the next step
//   Switch_3 : speed cycle 1x -> 2x -> 4x -> 1x, restarts the period
//   Switch_4 : single step while paused (only with LED_SEQ_STEP_EN defined)
//
// Optional feature macro: LED_SEQ_STEP_EN
//   defined   -> a Switch_4 edge in PAUSE steps the count once (no o_Tick)
//   undefined -> i_Switch_4 is unused, count changes only on ticks
//
// Parameters:
//   HALF_SECOND : cycles per count step at 1x speed (>= 4)
//   CNT_WIDTH   : divider width, must hold HALF_SECOND-1
//
// Ports:
//   i_Clk              system clock
//   i_Rst_L            asynchronous active-low reset
//   i_Switch_1..4      debounced switch levels
//   o_LED_1..o_LED_4   count bits 3..0 (registered)
//   o_Running          1 while in RUN state (registered)
//   o_Tick             one-cycle pulse on each automatic step (registered)
// -----------------------------------------------------------------------------
module led_counter_sequencer #(
  parameter int HALF_SECOND = 12_500_000,
  parameter int CNT_WIDTH   = 24
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4,
  output logic o_Running,
  output logic o_Tick
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

  // Terminal divider values for each speed (PERIOD - 1).
  localparam logic [CNT_WIDTH-1:0] PER1_M1 = CNT_WIDTH'(HALF_SECOND - 1);
  localparam logic [CNT_WIDTH-1:0] PER2_M1 = CNT_WIDTH'((HALF_SECOND >> 1) - 1);
  localparam logic [CNT_WIDTH-1:0] PER4_M1 = CNT_WIDTH'((HALF_SECOND >> 2) - 1);

  // One step of the 4-bit count, wrapping modulo 16. dir = 1 means down.
  function automatic logic [3:0] step_count(input logic [3:0] cnt, input logic dir);
    if (dir) begin
      step_count = cnt - 4'd1;
    end else begin
      step_count = cnt + 4'd1;
    end
  endfunction

  state_t               state_q, state_d;
  logic                 dir_q, dir_d;        // 0 = up, 1 = down
  logic [1:0]           speed_q, speed_d;    // 0 = 1x, 1 = 2x, 2 = 4x
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic [3:0]           count_q, count_d;
  logic                 tick_q, tick_d;
  logic [2:0]           prev_q;              // history of Switch_1..3
  logic [2:0]           sw_s;
  logic [2:0]           edge_s;
  logic [CNT_WIDTH-1:0] period_m1_s;
  logic                 wrap_s;
  logic                 div_clr_s;

  assign sw_s   = {i_Switch_3, i_Switch_2, i_Switch_1};
  assign edge_s = sw_s & ~prev_q;

`ifdef LED_SEQ_STEP_EN
  logic prev4_q;
  logic edge4_s;

  assign edge4_s = i_Switch_4 & ~prev4_q;

  // Switch_4 history register for the single-step edge detector.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      prev4_q <= 1'b0;
    end else begin
      prev4_q <= i_Switch_4;
    end
  end
`else
  logic unused_switch_4_s;
  assign unused_switch_4_s = i_Switch_4;
`endif

  // Select the terminal divider count for the current speed.
  always_comb begin
    period_m1_s = PER1_M1;
    case (speed_q)
      2'd0:    period_m1_s = PER1_M1;
      2'd1:    period_m1_s = PER2_M1;
      2'd2:    period_m1_s = PER4_M1;
      default: period_m1_s = PER1_M1;
    endcase
  end

  // A tick only occurs in RUN when the divider reaches its terminal value.
  // Pausing, resuming, a speed change or a wrap all restart the period.
  always_comb begin
    wrap_s    = (state_q == ST_RUN) && (div_q == period_m1_s);
    div_clr_s = wrap_s || (state_q == ST_PAUSE) || edge_s[0] || edge_s[2];
  end

  // Next-state logic: divider, count, direction, speed and run/pause.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    count_d = count_q;
    tick_d  = 1'b0;
    div_d   = div_q;

    if (div_clr_s) begin
      div_d = {CNT_WIDTH{1'b0}};
    end else begin
      div_d = div_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    // Steps always use the direction held before any same-cycle toggle.
    if (wrap_s) begin
      tick_d  = 1'b1;
      count_d = step_count(count_q, dir_q);
`ifdef LED_SEQ_STEP_EN
    end else if ((state_q == ST_PAUSE) && edge4_s && !edge_s[0]) begin
      count_d = step_count(count_q, dir_q);
`endif
    end else begin
      count_d = count_q;
    end

    if (edge_s[1]) begin
      dir_d = ~dir_q;
    end else begin
      dir_d = dir_q;
    end

    if (edge_s[2]) begin
      case (speed_q)
        2'd0:    speed_d = 2'd1;
        2'd1:    speed_d = 2'd2;
        default: speed_d = 2'd0;
      endcase
    end else begin
      speed_d = speed_q;
    end

    if (edge_s[0]) begin
      case (state_q)
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_RUN;
      dir_q   <= 1'b0;
      speed_q <= 2'd0;
      div_q   <= {CNT_WIDTH{1'b0}};
      count_q <= 4'd0;
      tick_q  <= 1'b0;
      prev_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      div_q   <= div_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      prev_q  <= sw_s;
    end
  end

  assign o_LED_1   = count_q[3];
  assign o_LED_2   = count_q[2];
  assign o_LED_3   = count_q[1];
  assign o_LED_4   = count_q[0];
  assign o_Running = (state_q == ST_RUN);
  assign o_Tick    = tick_q;

endmodule

// File: doc/led_counter_sequencer.md
Name: led_counter_sequencer

Overview:
Run-control and pacing controller for the 4-bit LED binary counter on the Go Board (25 MHz). Owns the tick divider and the 4-bit count register. Four debounced switch levels control it: run/pause, direction, speed and single-step. Drives the four LEDs (LED_1 = MSB, LED_4 = LSB) directly, replacing the free-running counter in the top level.

Parameters:
HALF_SECOND, 12_500_000, cycles per count step at 1x speed; must be >= 4 (benches use 50)
CNT_WIDTH, 24, width of the tick divider; must hold HALF_SECOND-1

Ports:
i_Clk  in  1  25 MHz system clock
i_Rst_L  in  1  asynchronous active-low reset
i_Switch_1  in  1  run/pause toggle, debounced level
i_Switch_2  in  1  direction toggle (up/down), debounced level
i_Switch_3  in  1  speed cycle, debounced level
i_Switch_4  in  1  single-step while paused (only used with the optional feature), debounced level
o_LED_1  out  1  count bit 3 (MSB)
o_LED_2  out  1  count bit 2
o_LED_3  out  1  count bit 1
o_LED_4  out  1  count bit 0 (LSB)
o_Running  out  1  1 = RUN state
o_Tick  out  1  single-cycle pulse on each automatic count step

Behaviour:
- One clock domain. Reset is asynchronous and active-low: i_Rst_L = 0 forces all state immediately, with no clock required.
- Reset values:
  - count = 0, so all LEDs are 0
  - state = RUN, direction = UP, speed = 1x
  - divider = 0, o_Tick = 0, o_Running = 1
  - switch history registers = 0
- Edge detection: edge_n = i_Switch_n & ~prev_n, where prev_n is registered every cycle.
  - Only rising edges act. Held levels do nothing.
  - A switch already high at reset release counts as an edge on the first clock.
  - An edge sampled at clock edge N takes effect in the registers at edge N.
- Period: PERIOD = HALF_SECOND >> speed_sel. speed_sel values:
  - 0 = 1x
  - 1 = 2x, period HALF_SECOND/2
  - 2 = 4x, period HALF_SECOND/4
- Switch_3 edge cycles the speed 1x -> 2x -> 4x -> 1x and clears the divider to 0 in the same cycle. speed_sel value 3 is unreachable.
- Divider (RUN state only):
  - If divider == PERIOD-1: divider <= 0, o_Tick <= 1 for one cycle, count steps.
  - Otherwise: divider increments and o_Tick <= 0.
  - First step after reset release occurs PERIOD cycles later. Steps then occur every PERIOD cycles.
- Count step:
  - UP: count+1 modulo 16, so 15 -> 0.
  - DOWN: count-1 modulo 16, so 0 -> 15.
  - Count width is exactly 4 bits; no carry out.
- State machine has two states: RUN and PAUSE.
  - RUN -> PAUSE on a Switch_1 edge. The divider is cleared to 0 and count is held.
  - PAUSE -> RUN on a Switch_1 edge. The first step comes a full PERIOD later.
  - In PAUSE the divider stays at 0 and o_Tick = 0.
- Switch_2 edge toggles direction in either state. It takes effect from the next step.
- Simultaneous events:
  - Tick and Switch_1 edge in the same cycle: the step is applied, then the state becomes PAUSE.
  - Tick and Switch_2 edge in the same cycle: the step uses the old direction.
  - Tick and Switch_3 edge in the same cycle: the step is applied, the speed changes, and the divider goes to 0.
  - Multiple switch edges in one cycle: all are applied independently.
- Reset mid-operation returns everything to reset values immediately, including mid-period and in PAUSE.
- LED outputs are registered, with no combinational path from the switches.

Optional Feature:
LED_SEQ_STEP_EN
- Defined:
  - A Switch_4 edge in PAUSE steps count once in the current direction on that clock edge.
  - o_Tick stays 0 for manual steps.
  - A Switch_4 edge in RUN is ignored.
  - A Switch_4 edge in the same cycle as a Switch_1 PAUSE -> RUN edge is ignored.
- Undefined:
  - i_Switch_4 is unused (port kept, tied off internally).
  - Count changes only on ticks.

Test Plan:
1. HALF_SECOND=50; release reset, no switches -> LEDs = 1 at 50 cycles after reset release, 2 at 100, ... 15 at 750, 0 at 800; o_Tick pulses exactly 16 times, one cycle each.
2. Pulse Switch_2 while count = 3 in RUN -> next steps 2, 1, 0, 15, each 50 cycles apart; hold Switch_2 high for 200 cycles -> only one toggle.
3. Pulse Switch_3 once -> steps every 25 cycles; pulse again -> every 12 cycles; pulse again -> back to every 50; each change restarts the period from 0.
4. Pulse Switch_1 at count = 5 -> o_Running = 0, LEDs stay 5 for 500 cycles, no o_Tick; pulse Switch_1 again -> o_Running = 1, LED = 6 exactly 50 cycles later.
5. Switch_1 edge timed on the cycle of the 4 -> 5 tick -> LEDs show 5 and state is PAUSE; assert i_Rst_L = 0 mid-period -> LEDs 0 immediately, no clock needed; resume at 1x, UP.
6. With LED_SEQ_STEP_EN: in PAUSE at count 9 with DOWN selected, three Switch_4 pulses -> LEDs 8, 7, 6 with o_Tick = 0; Switch_4 pulse in RUN -> no extra step. Without the macro, Switch_4 has no effect.
